// File: rtl/fpu_norm_pkg.sv
// Shared types and sizing helpers for the sequential mantissa normalizer.
package fpu_norm_pkg;

  localparam int unsigned LZC_CHUNK = 16;
  localparam int unsigned LZC_CW    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } norm_state_e;

  // Width able to hold a leading-zero count of 0..mant_w inclusive.
  function automatic int unsigned cnt_w(input int unsigned mant_w);
    return $clog2(mant_w) + 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/lzc_16.sv
// 16-bit leading-zero counter; o_v flags a non-zero input, o_c is 0 for a zero input.
module lzc_16
  import fpu_norm_pkg::*;
(
  input  logic [LZC_CHUNK-1:0] i_data,
  output logic [LZC_CW-1:0]    o_c,
  output logic                 o_v
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    o_c = '0;
    o_v = 1'b0;
    for (int i = 0; i < int'(LZC_CHUNK); i++) begin
      if (i_data[i]) begin
        o_c = LZC_CW'(int'(LZC_CHUNK) - 1 - i);
        o_v = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_norm_seq.sv
// Multi-cycle mantissa normalizer: scans 16-bit chunks MSB-first with one shared
// lzc_16, then shifts the mantissa and lowers the exponent by the total count.
module fpu_norm_seq
  import fpu_norm_pkg::*;
#(
  parameter int unsigned MANT_W = 32,
  parameter int unsigned EXP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MANT_W-1:0]        in_mant,
  input  logic [EXP_W-1:0]         in_exp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MANT_W-1:0]        out_mant,
  output logic [EXP_W-1:0]         out_exp,
  output logic [$clog2(MANT_W):0]  out_lzc,
  output logic                     out_zero,
  output logic                     out_uf,
  output logic                     busy
);

  localparam int unsigned NCHUNK = MANT_W / LZC_CHUNK;
  localparam int unsigned CNT_W  = cnt_w(MANT_W);
  localparam int unsigned IDX_W  = idx_w(NCHUNK);
  localparam int unsigned CMP_W  = (CNT_W > EXP_W) ? CNT_W : EXP_W;

  norm_state_e         r_state;
  norm_state_e         w_state_nxt;
  logic [MANT_W-1:0]   r_mant;
  logic [EXP_W-1:0]    r_exp;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_zero;
  logic                r_out_valid;

  logic [LZC_CHUNK-1:0] w_chunk;
  logic                 w_chunk_zero;
  logic                 w_last_chunk;
  logic [LZC_CW-1:0]    w_lzc_c;
  logic                 w_lzc_v;
  logic [CMP_W-1:0]     w_cnt_ext;
  logic [CMP_W-1:0]     w_exp_ext;
  logic [CMP_W-1:0]     w_exp_sub;
  logic                 w_uf;
  logic [CNT_W-1:0]     w_shamt;
  logic [MANT_W-1:0]    w_shifted;

  // Chunk mux feeding the single shared counter.
  assign w_chunk      = r_mant[LZC_CHUNK*int'(r_idx) +: LZC_CHUNK];
  assign w_chunk_zero = (w_chunk == '0);
  assign w_last_chunk = (r_idx == '0);

  lzc_16 u_lzc (
    .i_data (w_chunk),
    .o_c    (w_lzc_c),
    .o_v    (w_lzc_v)
  );

  // Underflow: the count cannot be fully absorbed by the exponent, so shift only by in_exp.
  assign w_cnt_ext = CMP_W'(r_cnt);
  assign w_exp_ext = CMP_W'(r_exp);
  assign w_uf      = (w_cnt_ext > w_exp_ext);
  assign w_exp_sub = w_exp_ext - w_cnt_ext;
  assign w_shamt   = w_uf ? CNT_W'(r_exp) : r_cnt;
  assign w_shifted = r_mant << w_shamt;

  assign out_valid = r_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = SCAN;
      end
      SCAN: begin
        if (!w_chunk_zero || w_last_chunk) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        if (r_out_valid && out_ready) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mant      <= '0;
      r_exp       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      out_mant    <= '0;
      out_exp     <= '0;
      out_lzc     <= '0;
      out_zero    <= 1'b0;
      out_uf      <= 1'b0;
    end else begin
      // Result is presented one cycle after entering DONE and held until taken.
      r_out_valid <= (r_state == DONE) && !(r_out_valid && out_ready);
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mant <= in_mant;
            r_exp  <= in_exp;
            r_idx  <= IDX_W'(NCHUNK - 1);
            r_cnt  <= '0;
            r_zero <= 1'b0;
          end
        end
        SCAN: begin
          if (w_chunk_zero) begin
            r_cnt <= r_cnt + CNT_W'(LZC_CHUNK);
            if (w_last_chunk) r_zero <= 1'b1;
            else              r_idx  <= r_idx - IDX_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(w_lzc_c);
          end
        end
        SHIFT: begin
          out_lzc <= r_cnt;
          if (r_zero) begin
            out_mant <= '0;
            out_exp  <= '0;
            out_zero <= 1'b1;
            out_uf   <= 1'b0;
          end else begin
            out_mant <= w_shifted;
            out_exp  <= w_uf ? '0 : EXP_W'(w_exp_sub);
            out_zero <= 1'b0;
            out_uf   <= w_uf;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The counter's valid flag must agree with the local zero test.
  always_ff @(posedge clk) begin
    if (!rst && r_state == SCAN) begin
      assert (w_lzc_v == !w_chunk_zero);
    end
  end

endmodule

// File: tb/tb_fpu_norm_seq.sv
// Scoreboard bench for fpu_norm_seq: directed vectors pushed as issued, checked by a monitor.
module tb_fpu_norm_seq;

  localparam int unsigned MANT_W = 32;
  localparam int unsigned EXP_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_mant;
  logic [7:0]        in_exp;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_mant;
  logic [7:0]        out_exp;
  logic [5:0]        out_lzc;
  logic              out_zero;
  logic              out_uf;
  logic              busy;

  typedef struct {
    logic [31:0] mant;
    logic [7:0]  exp;
    logic [5:0]  lzc;
    logic        zero;
    logic        uf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   seen_valid = 1'b0;

  fpu_norm_seq #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_lzc   (out_lzc),
    .out_zero  (out_zero),
    .out_uf    (out_uf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: latency on first sight of out_valid, payload on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen_valid = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got out_valid=1, want no pending result");
        end else begin
          if (!seen_valid) begin
            seen_valid = 1'b1;
            chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          end
          if (out_ready) begin
            chk("out_mant", 64'(out_mant), 64'(sb[0].mant));
            chk("out_exp",  64'(out_exp),  64'(sb[0].exp));
            chk("out_lzc",  64'(out_lzc),  64'(sb[0].lzc));
            chk("out_zero", 64'(out_zero), 64'(sb[0].zero));
            chk("out_uf",   64'(out_uf),   64'(sb[0].uf));
            void'(sb.pop_front());
            seen_valid = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] mant, input logic [7:0] exp,
                      input logic [31:0] e_mant, input logic [7:0] e_exp,
                      input logic [5:0] e_lzc, input logic e_zero, input logic e_uf,
                      input int lat);
    exp_t e;
    int   t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'(1));
      return;
    end
    in_valid = 1'b1;
    in_mant  = mant;
    in_exp   = exp;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.mant = e_mant; e.exp = e_exp; e.lzc = e_lzc;
    e.zero = e_zero; e.uf  = e_uf;  e.lat = lat; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'(1));
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_mant"},  64'(out_mant),  64'(0));
    chk({tag, "_out_exp"},   64'(out_exp),   64'(0));
    chk({tag, "_out_lzc"},   64'(out_lzc),   64'(0));
    chk({tag, "_out_zero"},  64'(out_zero),  64'(0));
    chk({tag, "_out_uf"},    64'(out_uf),    64'(0));
  endtask

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk); #1;

    send(32'h0000_8000, 8'd40,  32'h8000_0000, 8'd24,  6'd16, 1'b0, 1'b0, 4);
    send(32'h8000_0000, 8'd1,   32'h8000_0000, 8'd1,   6'd0,  1'b0, 1'b0, 3);
    send(32'h0000_0000, 8'd100, 32'h0000_0000, 8'd0,   6'd32, 1'b1, 1'b0, 4);
    send(32'h0001_0000, 8'd10,  32'h0400_0000, 8'd0,   6'd15, 1'b0, 1'b1, 3);
    send(32'h0000_0001, 8'd31,  32'h8000_0000, 8'd0,   6'd31, 1'b0, 1'b0, 4);
    send(32'h0000_0001, 8'd30,  32'h4000_0000, 8'd0,   6'd31, 1'b0, 1'b1, 4);
    send(32'h1234_5678, 8'd255, 32'h91A2_B3C0, 8'd252, 6'd3,  1'b0, 1'b0, 3);
    send(32'h0000_FFFF, 8'd16,  32'hFFFF_0000, 8'd0,   6'd16, 1'b0, 1'b0, 4);
    drain();

    // Back-pressure in DONE with a stray in_valid that must be ignored.
    out_ready = 1'b0;
    send(32'h00F0_0000, 8'd50, 32'hF000_0000, 8'd42, 6'd8, 1'b0, 1'b0, 3);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_out_valid_seen", 64'(out_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_mant = 32'hDEAD_BEEF; in_exp = 8'd7;
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_in_ready",  64'(in_ready),  64'(0));
      chk("bp_out_mant",  64'(out_mant),  64'(32'hF000_0000));
      chk("bp_out_exp",   64'(out_exp),   64'(42));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_in_ready",  64'(in_ready),  64'(1));
    chk("hs_out_valid", 64'(out_valid), 64'(0));
    chk("hs_hold_mant", 64'(out_mant),  64'(32'hF000_0000));
    repeat (6) @(posedge clk);
    #1;
    chk("stray_sb_empty", 64'(sb.size()), 64'(0));
    chk("stray_busy",     64'(busy),      64'(0));

    // Reset in the middle of a scan aborts the operation.
    in_valid = 1'b1; in_mant = 32'h0000_8000; in_exp = 8'd40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("scan_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("mid");
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'h8000_0000, 8'd1, 32'h8000_0000, 8'd1, 6'd0, 1'b0, 1'b0, 3);
    drain();
    repeat (6) @(posedge clk);
    #1;
    chk("final_idle", 64'(in_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

endmodule
